// File: rtl/fetch_stage_pkg.sv
// -----------------------------------------------------------------------------
// fetch_stage_pkg
// Shared types for the instruction-fetch stage and the hazard control unit.
//   pcsrc_t       : PC source select driven by the hazard unit.
//   fetch_state_t : fetch FSM state encoding.
//   NOP_INSTR     : RV32 canonical NOP (addi x0, x0, 0) shown when no
//                   instruction is held.
// -----------------------------------------------------------------------------
package fetch_stage_pkg;

   typedef enum logic [1:0] {
      PCSRC_NEXT_PC        = 2'b00,
      PCSRC_BRANCH_ALU     = 2'b01,
      PCSRC_BRANCH_PC_JUMP = 2'b10,
      PCSRC_NOP            = 2'b11
   } pcsrc_t;

   typedef enum logic [2:0] {
      FS_IDLE  = 3'd0,
      FS_REQ   = 3'd1,
      FS_WAIT  = 3'd2,
      FS_READY = 3'd3,
      FS_ERR   = 3'd4
   } fetch_state_t;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage : fetch_stage_pkg

// File: rtl/fetch_next_pc.sv
// -----------------------------------------------------------------------------
// fetch_next_pc
// Combinational next-PC selection for the fetch stage.
// Ports:
//   pc              in   current PC
//   pc_src          in   hazard-unit PC source select
//   branch_alu      in   ALU-computed branch target
//   branch_pc_jump  in   PC-relative jump target
//   redirect_alu    in   redirect target select (1 = ALU, 0 = PC-relative)
//   next_pc         out  PC to load when the hazard unit lets the PC advance
//   redirect_target out  word-aligned target for a MEM-stage redirect
// Sequential PC wraps modulo 2^XLEN; branch/jump targets are word-aligned by
// clearing bits [1:0].
// -----------------------------------------------------------------------------
module fetch_next_pc
   import fetch_stage_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic [XLEN-1:0] pc,
   input  pcsrc_t          pc_src,
   input  logic [XLEN-1:0] branch_alu,
   input  logic [XLEN-1:0] branch_pc_jump,
   input  logic            redirect_alu,
   output logic [XLEN-1:0] next_pc,
   output logic [XLEN-1:0] redirect_target
);

   localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

   logic [XLEN-1:0] alu_aligned;
   logic [XLEN-1:0] jump_aligned;

   assign alu_aligned  = branch_alu & ALIGN_MASK;
   assign jump_aligned = branch_pc_jump & ALIGN_MASK;

   always_comb begin
      unique case (pc_src)
         PCSRC_NEXT_PC:        next_pc = pc + XLEN'(4);
         PCSRC_BRANCH_ALU:     next_pc = alu_aligned;
         PCSRC_BRANCH_PC_JUMP: next_pc = jump_aligned;
         default:              next_pc = pc;
      endcase
   end

   assign redirect_target = redirect_alu ? alu_aligned : jump_aligned;

endmodule : fetch_next_pc

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// Instruction-fetch stage: owns the PC and a single-outstanding
// req/gnt/rvalid handshake to instruction memory, and presents the fetched
// {pc, instr, valid} to the IF/ID register.
// Ports:
//   clk, rst_n         clock; synchronous active-low reset
//   pc_src_i, en_pc_i  PC source and enable from the hazard unit
//   branch_alu_i       ALU branch target
//   branch_pc_jump_i   PC-relative jump target
//   redirect_i         raw taken-branch/jump from MEM (acted on in REQ/WAIT)
//   redirect_alu_i     redirect target select (1 = ALU, 0 = PC-relative)
//   imem_req_o/addr_o  memory request and address (held until gnt)
//   imem_gnt_i         request accepted
//   imem_rvalid_i      read data valid, imem_rdata_i instruction word
//   fsm_pcsrc_o        instruction ready, PC may advance (READY only)
//   if_pc_o/instr_o    held instruction and its PC (NOP / 0 when invalid)
//   if_valid_o         held instruction valid
//   fetch_err_o        sticky fetch timeout
// Build option: define FETCH_TIMEOUT_EN to add the WAIT timeout and ERR state;
// without it WAIT may last indefinitely and fetch_err_o is tied low.
// -----------------------------------------------------------------------------
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter int unsigned     XLEN           = 32,
   parameter logic [XLEN-1:0] RESET_PC       = '0,
   parameter int unsigned     TIMEOUT_CYCLES = 255
) (
   input  logic            clk,
   input  logic            rst_n,
   input  pcsrc_t          pc_src_i,
   input  logic            en_pc_i,
   input  logic [XLEN-1:0] branch_alu_i,
   input  logic [XLEN-1:0] branch_pc_jump_i,
   input  logic            redirect_i,
   input  logic            redirect_alu_i,
   output logic            imem_req_o,
   output logic [XLEN-1:0] imem_addr_o,
   input  logic            imem_gnt_i,
   input  logic            imem_rvalid_i,
   input  logic [31:0]     imem_rdata_i,
   output logic            fsm_pcsrc_o,
   output logic [XLEN-1:0] if_pc_o,
   output logic [31:0]     if_instr_o,
   output logic            if_valid_o,
   output logic            fetch_err_o
);

   fetch_state_t    state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] pend_pc_q, pend_pc_d;
   logic [31:0]     instr_q, instr_d;
   logic            kill_q, kill_d;

   logic [XLEN-1:0] next_pc;
   logic [XLEN-1:0] redirect_target;
   logic            data_ret;
   logic            timeout;

   fetch_next_pc #(.XLEN(XLEN)) u_next_pc (
      .pc              (pc_q),
      .pc_src          (pc_src_i),
      .branch_alu      (branch_alu_i),
      .branch_pc_jump  (branch_pc_jump_i),
      .redirect_alu    (redirect_alu_i),
      .next_pc         (next_pc),
      .redirect_target (redirect_target)
   );

   // Read data belongs to our request only when it arrives with the grant in
   // REQ or any time in WAIT; stray beats elsewhere are dropped.
   assign data_ret = imem_rvalid_i &&
                     (((state_q == FS_REQ) && imem_gnt_i) || (state_q == FS_WAIT));

`ifdef FETCH_TIMEOUT_EN
   localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [TO_W-1:0] to_cnt_q;

   // Counter sits at zero outside WAIT, so it starts cleared on every entry.
   always_ff @(posedge clk) begin
      if (!rst_n)                  to_cnt_q <= '0;
      else if (state_q != FS_WAIT) to_cnt_q <= '0;
      else                         to_cnt_q <= to_cnt_q + 1'b1;
   end

   // Fires on the WAIT cycle whose increment would reach TIMEOUT_CYCLES.
   assign timeout = (state_q == FS_WAIT) && !imem_rvalid_i &&
                    (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
   assign fetch_err_o = (state_q == FS_ERR);
`else
   assign timeout     = 1'b0;
   assign fetch_err_o = 1'b0;
`endif

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values; the reset here is synchronous (inside the edge).
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= FS_IDLE;
         pc_q      <= RESET_PC;
         pend_pc_q <= '0;
         instr_q   <= NOP_INSTR;
         kill_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         pend_pc_q <= pend_pc_d;
         instr_q   <= instr_d;
         kill_q    <= kill_d;
      end
   end

   // NOTE: every signal is given its hold value first so no path through the
   // case statement can leave one unassigned and infer a latch.
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      pend_pc_d = pend_pc_q;
      instr_d   = instr_q;
      kill_d    = kill_q;

      case (state_q)
         FS_IDLE: state_d = FS_REQ;

         FS_REQ, FS_WAIT: begin
            if (data_ret) begin
               // A redirect seen before or with the return makes this fetch
               // wrong-path: drop it and refetch from the newest target.
               if (kill_q || redirect_i) begin
                  pc_d    = redirect_i ? redirect_target : pend_pc_q;
                  kill_d  = 1'b0;
                  state_d = FS_REQ;
               end else begin
                  instr_d = imem_rdata_i;
                  state_d = FS_READY;
               end
            end else begin
               // The outstanding request is never withdrawn; the redirect is
               // remembered and the later one wins.
               if (redirect_i) begin
                  kill_d    = 1'b1;
                  pend_pc_d = redirect_target;
               end
               if ((state_q == FS_REQ) && imem_gnt_i) state_d = FS_WAIT;
               if (timeout)                           state_d = FS_ERR;
            end
         end

         FS_READY: begin
            if (en_pc_i && (pc_src_i != PCSRC_NOP)) begin
               pc_d    = next_pc;
               state_d = FS_REQ;
            end
         end

         FS_ERR: state_d = FS_ERR;

         default: state_d = FS_IDLE;
      endcase
   end

   assign imem_req_o  = (state_q == FS_REQ);
   assign imem_addr_o = pc_q;
   assign fsm_pcsrc_o = (state_q == FS_READY);
   assign if_valid_o  = (state_q == FS_READY);
   assign if_pc_o     = if_valid_o ? pc_q : '0;
   assign if_instr_o  = if_valid_o ? instr_q : NOP_INSTR;

endmodule : fetch_stage

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
// Directed steps followed by randomized memory/hazard traffic for fetch_stage.
// The reference model tracks fetches as transactions: which address must be
// requested next, whether a grant is outstanding, whether the returning data
// is wrong-path, and which instruction must be on the IF/ID outputs.
// -----------------------------------------------------------------------------
module tb_fetch_stage;
   import fetch_stage_pkg::*;

   localparam int unsigned   TO       = 4;
   localparam logic [31:0]   RESET_PC = 32'h0000_0000;
`ifdef FETCH_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   pcsrc_t      pc_src;
   logic        en_pc;
   logic [31:0] br_alu, br_jmp;
   logic        redirect, redirect_alu;
   logic        imem_req, imem_gnt, imem_rvalid;
   logic [31:0] imem_addr, imem_rdata;
   logic        fsm_pcsrc, if_valid, fetch_err;
   logic [31:0] if_pc, if_instr;

   fetch_stage #(.XLEN(32), .RESET_PC(RESET_PC), .TIMEOUT_CYCLES(TO)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .pc_src_i         (pc_src),
      .en_pc_i          (en_pc),
      .branch_alu_i     (br_alu),
      .branch_pc_jump_i (br_jmp),
      .redirect_i       (redirect),
      .redirect_alu_i   (redirect_alu),
      .imem_req_o       (imem_req),
      .imem_addr_o      (imem_addr),
      .imem_gnt_i       (imem_gnt),
      .imem_rvalid_i    (imem_rvalid),
      .imem_rdata_i     (imem_rdata),
      .fsm_pcsrc_o      (fsm_pcsrc),
      .if_pc_o          (if_pc),
      .if_instr_o       (if_instr),
      .if_valid_o       (if_valid),
      .fetch_err_o      (fetch_err)
   );

   int n_vec = 0;
   int n_err = 0;

   // Transaction-level reference state.
   bit          m_idle, m_req, m_out, m_ready, m_kill, m_err;
   logic [31:0] m_addr, m_target, m_instr;
   int          m_wait;
   bit          auto_rdata;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0] ^ 16'h5A3C, a[31:16] ^ 16'hC3A5} + 32'h0101_0000;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Predict the effect of the inputs currently driven at the next edge.
   task automatic model_update();
      logic [31:0] tgt;
      bit          ret;
      tgt = (redirect_alu ? br_alu : br_jmp) & ~32'h3;
      if (!rst_n) begin
         m_idle = 1; m_req = 0; m_out = 0; m_ready = 0; m_kill = 0; m_err = 0;
         m_addr = RESET_PC; m_wait = 0;
         return;
      end
      if (m_err) return;
      if (m_idle) begin
         m_idle = 0; m_req = 1;
         return;
      end
      if (m_ready) begin
         if (en_pc && pc_src != PCSRC_NOP) begin
            if (pc_src == PCSRC_NEXT_PC)         m_addr = m_addr + 32'd4;
            else if (pc_src == PCSRC_BRANCH_ALU) m_addr = br_alu & ~32'h3;
            else                                 m_addr = br_jmp & ~32'h3;
            m_ready = 0; m_req = 1;
         end
         return;
      end
      ret = imem_rvalid && ((m_req && imem_gnt) || m_out);
      if (ret) begin
         m_req = 0; m_out = 0;
         if (m_kill || redirect) begin
            m_addr = redirect ? tgt : m_target;
            m_kill = 0; m_req = 1;
         end else begin
            m_instr = imem_rdata; m_ready = 1;
         end
      end else begin
         if (redirect) begin
            m_kill = 1; m_target = tgt;
         end
         if (m_out) begin
            m_wait++;
            if (TO_EN && m_wait == TO) begin
               m_err = 1; m_out = 0;
            end
         end else if (m_req && imem_gnt) begin
            m_req = 0; m_out = 1; m_wait = 0;
         end
      end
   endtask

   task automatic check_all();
      check("req", imem_req, 32'(m_req));
      if (m_req) check("addr", imem_addr, m_addr);
      check("fsm_pcsrc", fsm_pcsrc, 32'(m_ready));
      check("valid", if_valid, 32'(m_ready));
      check("if_pc", if_pc, m_ready ? m_addr : 32'h0);
      check("if_instr", if_instr, m_ready ? m_instr : NOP_INSTR);
      check("err", fetch_err, 32'(m_err));
   endtask

   task automatic step();
      if (auto_rdata) imem_rdata = mem_word(m_addr);
      model_update();
      @(posedge clk);
      @(negedge clk);
      check_all();
   endtask

   task automatic mem_io(input logic gnt, input logic rvalid);
      imem_gnt    = gnt;
      imem_rvalid = rvalid;
   endtask

   task automatic rand_inputs();
      rst_n        = ($urandom_range(99) != 0);
      pc_src       = pcsrc_t'(2'($urandom_range(3)));
      en_pc        = m_ready && ($urandom_range(3) != 0);
      br_alu       = $urandom;
      br_jmp       = ($urandom_range(7) == 0) ? 32'hFFFF_FFFD : $urandom;
      redirect     = ($urandom_range(5) == 0);
      redirect_alu = 1'($urandom_range(1));
      imem_gnt     = 1'($urandom_range(1));
      imem_rvalid  = 1'b0;
      imem_rdata   = $urandom;
      if (m_req && imem_gnt) begin
         if ($urandom_range(1) != 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(m_addr);
         end
      end else if (m_out) begin
         if ($urandom_range(2) == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(m_addr);
         end
      end else if ($urandom_range(9) == 0) begin
         imem_rvalid = 1'b1;   // stray beat with nothing outstanding
      end
   endtask

   initial begin
      rst_n = 1'b0; pc_src = PCSRC_NEXT_PC; en_pc = 1'b0;
      br_alu = '0; br_jmp = '0; redirect = 1'b0; redirect_alu = 1'b0;
      imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
      m_idle = 1; m_req = 0; m_out = 0; m_ready = 0; m_kill = 0; m_err = 0;
      m_addr = RESET_PC; m_target = '0; m_instr = NOP_INSTR; m_wait = 0;
      auto_rdata = 1'b1;
      @(negedge clk);

      // Reset, with a stray rvalid that must be ignored.
      mem_io(1'b1, 1'b1);
      step(); step();
      check("rst_req", imem_req, 32'h0);
      check("rst_valid", if_valid, 32'h0);
      check("rst_instr", if_instr, 32'h0000_0013);
      check("rst_pc", if_pc, 32'h0);
      check("rst_err", fetch_err, 32'h0);

      // Zero-wait sequential fetch.
      rst_n = 1'b1; en_pc = 1'b1; pc_src = PCSRC_NEXT_PC;
      step();
      check("seq_addr0", imem_addr, 32'h0);
      step();
      check("seq_valid0", if_valid, 32'h1);
      check("seq_instr0", if_instr, mem_word(32'h0));
      step();
      check("seq_addr1", imem_addr, 32'h4);
      check("seq_gap1", if_valid, 32'h0);
      step();
      check("seq_instr1", if_instr, mem_word(32'h4));
      step();
      check("seq_addr2", imem_addr, 32'h8);
      step();

      // Load-use stall: hold for three cycles.
      en_pc = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         check("stall_fsm", fsm_pcsrc, 32'h1);
         check("stall_req", imem_req, 32'h0);
         check("stall_pc", if_pc, 32'h8);
      end

      // Branch via ALU target, misaligned.
      en_pc = 1'b1; pc_src = PCSRC_BRANCH_ALU; br_alu = 32'h0000_0103;
      step();
      check("alu_addr", imem_addr, 32'h100);

      // Grant without data, then redirect in WAIT; returning data is discarded.
      mem_io(1'b1, 1'b0); step();
      check("wait_req", imem_req, 32'h0);
      mem_io(1'b0, 1'b0);
      redirect = 1'b1; redirect_alu = 1'b0; br_jmp = 32'h0000_0200;
      step();
      redirect = 1'b0; br_jmp = 32'h0; mem_io(1'b0, 1'b1);
      step();
      check("kill_valid", if_valid, 32'h0);
      check("kill_addr", imem_addr, 32'h200);
      mem_io(1'b1, 1'b1); step();
      check("kill_pc", if_pc, 32'h200);

      // PC wrap after the last word.
      pc_src = PCSRC_BRANCH_PC_JUMP; br_jmp = 32'hFFFF_FFFF;
      step();
      check("wrap_hi", imem_addr, 32'hFFFF_FFFC);
      step();
      pc_src = PCSRC_NEXT_PC;
      step();
      check("wrap_addr", imem_addr, 32'h0);
      step();

      // Long WAIT: times out with the feature, waits forever without it.
      step();
      mem_io(1'b1, 1'b0); step();
      mem_io(1'b0, 1'b0);
`ifdef FETCH_TIMEOUT_EN
      for (int i = 0; i < 3; i++) step();
      check("to_early", fetch_err, 32'h0);
      step();
      check("to_err", fetch_err, 32'h1);
      check("to_req", imem_req, 32'h0);
      step();
      check("to_sticky", fetch_err, 32'h1);
      rst_n = 1'b0; step();
      check("to_clear", fetch_err, 32'h0);
      rst_n = 1'b1; step();
      check("to_refetch", imem_addr, RESET_PC);
`else
      for (int i = 0; i < 10; i++) step();
      check("nto_err", fetch_err, 32'h0);
      check("nto_valid", if_valid, 32'h0);
      mem_io(1'b0, 1'b1); step();
      check("nto_data", if_instr, mem_word(32'h4));
`endif

      // Randomized traffic.
      auto_rdata = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         rand_inputs();
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_fetch_stage
